serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 CLK  input  1: single clock; all state changes on its rising edge.
REQ-003 RST_N  input  1: reset, asynchronous, active-low.
REQ-004 START  input  1: request a new subtraction; sampled only in IDLE.
REQ-005 A  input  WIDTH: minuend; captured on the accepting edge.
REQ-006 B  input  WIDTH: subtrahend; captured on the accepting edge.
REQ-007 BIN  input  1: borrow-in; captured on the accepting edge.
REQ-008 BUSY  output  1: high while an operation is in progress (RUN state).
REQ-009 DONE  output  1: single-cycle pulse marking D and BOUT as newly valid.
REQ-010 D  output  WIDTH: difference A - B - BIN, modulo 2^WIDTH.
REQ-011 BOUT  output  1: borrow-out; high when A < B + BIN (unsigned).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-013 IDLE -> RUN on an edge with START=1; A, B and BIN are captured on that same edge, and the bit counter is cleared to 0.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through one full-subtractor cell: diff = a^b^bw; borrow = (~a&b) | (~(a^b)&bw).
REQ-015 The borrow register SHALL start at the captured BIN and carry each bit's borrow into the next bit.
REQ-016 RUN -> FIN on the edge that processes bit WIDTH-1, i.e. the WIDTH-th RUN edge after acceptance.
REQ-017 FIN -> IDLE unconditionally on the next edge; START is ignored in FIN.
REQ-018 Latency: START accepted at edge k; DONE=1 for the cycle following edge k+WIDTH; the block is back in IDLE after edge k+WIDTH+1.
REQ-019 BUSY SHALL be 1 only in RUN; DONE SHALL be 1 only in FIN; both are registered.
REQ-020 D and BOUT SHALL update only on the RUN -> FIN edge.
REQ-021 D and BOUT SHALL hold their previous values while RUN is active and until the next completion.
REQ-022 START during RUN or FIN SHALL be ignored; A, B and BIN changes after acceptance SHALL not affect the result.
REQ-023 Back-to-back operation: START held high SHALL be accepted on the first edge after FIN, in IDLE, with a throughput of one result per WIDTH+2 cycles.
REQ-024 Wrap-around: all-zero operands with BIN=1 SHALL give D = all ones and BOUT=1.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide; it SHALL be unused outside RUN and never wrap within an operation.

Reset
REQ-026 RST_N=0 SHALL immediately, without waiting for a clock edge, force state IDLE, BUSY=0, DONE=0, D=0, BOUT=0, counter=0, and clear the shift and borrow registers.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation; no DONE pulse results from it.
REQ-028 On the first edge after RST_N rises, START SHALL be honoured if high.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, RUN, FIN) and the default WIDTH constant.
REQ-030 The bit-level arithmetic SHALL live in one combinational sub-module, full_subtractor (ports A, B, BIN -> D, BOUT), instantiated once.
REQ-031 The top level SHALL contain only the FSM, the counter, the operand and difference shift registers, the borrow register and the output registers.

Verification
REQ-032 WIDTH=8, A=8'h05, B=8'h03, BIN=0, START one cycle -> DONE pulse 8 edges after acceptance with D=8'h02, BOUT=0; BUSY high for exactly 8 cycles.
REQ-033 A=8'h03, B=8'h05, BIN=0 -> D=8'hFE, BOUT=1.
REQ-034 A=8'h00, B=8'h00, BIN=1 -> D=8'hFF, BOUT=1; then A=8'hFF, B=8'h7F, BIN=1 -> D=8'h7F, BOUT=0.
REQ-035 Start A=8'h10, B=8'h01; at RUN cycle 3 pulse START with A=8'hAA and change B -> result D=8'h0F only, with one DONE pulse.
REQ-036 Drop RST_N at RUN cycle 4 -> outputs 0 at once, no DONE; after release, a fresh START with A=8'h09, B=8'h04 -> D=8'h05.
REQ-037 START held high continuously -> DONE pulses exactly 10 cycles apart, each with the correct result for the operands present at that acceptance edge.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell used by the serial datapath.
// Ports: A, B, BIN in; D = A-B-BIN bit, BOUT = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic D,
    output logic BOUT
);

    assign D    = A ^ B ^ BIN;
    assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - BIN, LSB first, one bit/cycle.
// Ports: CLK, RST_N, START, A, B, BIN in; BUSY, DONE, D, BOUT out.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .BIN  (bw_q),
        .D    (fs_d),
        .BOUT (fs_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bw_d    = bw_q;
        d_d     = d_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = A;
                    b_d     = B;
                    bw_d    = BIN;
                end
            end
            RUN: begin
                // Difference bits enter at the MSB end so that after
                // WIDTH shifts bit 0 sits at position 0.
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                bw_d   = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = FIN;
                    cnt_d   = '0;
                    d_d     = {fs_d, diff_q[WIDTH-1:1]};
                    bout_d  = fs_bout;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bw_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bw_q    <= bw_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign D    = d_q;
    assign BOUT = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Random and directed operations against an arithmetic reference.
module tb_serial_subtractor;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic       BIN;
    logic       BUSY;
    logic       DONE;
    logic [7:0] D;
    logic       BOUT;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: plain unsigned arithmetic, result is {bout, d}.
    function automatic logic [8:0] ref_sub(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic bin);
        int diff;
        logic bout;
        diff = int'(a) - int'(b) - int'(bin);
        bout = int'(a) < (int'(b) + int'(bin));
        return {bout, 8'(diff)};
    endfunction

    // Stimulus only: launch one operation, scramble inputs after
    // acceptance, and wait (bounded) for DONE.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input bit rel_rst,
                         output int lat, output int busy_n,
                         output bit held);
        logic [7:0] d0;
        @(negedge CLK);
        A = a; B = b; BIN = bin; START = 1'b1;
        if (rel_rst) RST_N = 1'b1;
        d0 = D;
        @(negedge CLK);
        START = 1'b0;
        A = 8'($urandom); B = 8'($urandom); BIN = 1'($urandom);
        lat = 0; busy_n = 0; held = 1'b1;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) busy_n++;
            if (D !== d0) held = 1'b0;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; START = 1'b0; A = '0; B = '0; BIN = 1'b0;
        #3;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", BUSY);
        end
        checks++;
        if (DONE !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b want 0", DONE);
        end
        checks++;
        if (D !== 8'h00) begin
            errors++; $display("FAIL reset_d got %h want 00", D);
        end
        checks++;
        if (BOUT !== 1'b0) begin
            errors++; $display("FAIL reset_bout got %b want 0", BOUT);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_directed;
        logic [7:0] ta [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
        logic [7:0] tb [4] = '{8'h03, 8'h05, 8'h00, 8'h7F};
        logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h7F};
        logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int lat, busy_n;
        bit held;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], 1'b0, lat, busy_n, held);
            checks++;
            if (lat !== 8) begin
                errors++; $display("FAIL dir%0d_latency got %0d want 8", i, lat);
            end
            checks++;
            if (busy_n !== 8) begin
                errors++; $display("FAIL dir%0d_busy got %0d want 8", i, busy_n);
            end
            checks++;
            if (D !== ed[i] || BOUT !== eb[i]) begin
                errors++;
                $display("FAIL dir%0d_result got %h/%b want %h/%b",
                         i, D, BOUT, ed[i], eb[i]);
            end
            checks++;
            if (!held) begin
                errors++; $display("FAIL dir%0d_hold got changed want held", i);
            end
            @(negedge CLK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_pulse got done=%b busy=%b want 0/0",
                         i, DONE, BUSY);
            end
        end
    endtask

    task automatic test_random;
        int lat, busy_n;
        bit held;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] exp;
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = ref_sub(ra, rb, rc);
            do_op(ra, rb, rc, 1'b0, lat, busy_n, held);
            checks++;
            if (lat !== 8 || D !== exp[7:0] || BOUT !== exp[8]) begin
                errors++;
                $display("FAIL rnd%0d %h-%h-%b got %h/%b lat %0d want %h/%b lat 8",
                         i, ra, rb, rc, D, BOUT, lat, exp[7:0], exp[8]);
            end
        end
    endtask

    task automatic test_midstart;
        int pulses;
        logic [7:0] got_d;
        logic got_b;
        pulses = 0; got_d = '0; got_b = 1'b0;
        @(negedge CLK);
        A = 8'h10; B = 8'h01; BIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        A = 8'hAA; B = 8'h55; BIN = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (DONE === 1'b1) begin
                pulses++; got_d = D; got_b = BOUT;
            end
            @(negedge CLK);
        end
        checks++;
        if (pulses !== 1) begin
            errors++; $display("FAIL midstart_pulses got %0d want 1", pulses);
        end
        checks++;
        if (got_d !== 8'h0F || got_b !== 1'b0) begin
            errors++;
            $display("FAIL midstart_result got %h/%b want 0f/0", got_d, got_b);
        end
    endtask

    task automatic test_reset_mid;
        int lat, busy_n, pulses;
        bit held;
        @(negedge CLK);
        A = 8'h77; B = 8'h11; BIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || D !== 8'h00 || BOUT !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got busy=%b done=%b d=%h bout=%b want 0/0/00/0",
                     BUSY, DONE, D, BOUT);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL midreset_nodone got %0d want 0", pulses);
        end
        do_op(8'h09, 8'h04, 1'b0, 1'b1, lat, busy_n, held);
        checks++;
        if (lat !== 8 || D !== 8'h05 || BOUT !== 1'b0) begin
            errors++;
            $display("FAIL midreset_restart got %h/%b lat %0d want 05/0 lat 8",
                     D, BOUT, lat);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        logic [7:0] oa [64];
        logic [7:0] ob [64];
        logic       oc [64];
        int pulses;
        logic [8:0] exp;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                checks++;
                exp = ref_sub(oa[c-9], ob[c-9], oc[c-9]);
                if (c !== 9 + 10 * pulses || D !== exp[7:0] || BOUT !== exp[8]) begin
                    errors++;
                    $display("FAIL b2b%0d got cyc %0d %h/%b want cyc %0d %h/%b",
                             pulses, c, D, BOUT, 9 + 10 * pulses, exp[7:0], exp[8]);
                end
                pulses++;
            end
            oa[c] = 8'($urandom); ob[c] = 8'($urandom); oc[c] = 1'($urandom);
            A = oa[c]; B = ob[c]; BIN = oc[c]; START = 1'b1;
        end
        START = 1'b0;
        checks++;
        if (pulses !== 4) begin
            errors++; $display("FAIL b2b_count got %0d want 4", pulses);
        end
        repeat (12) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_midstart();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
